mux_rr_scheduler: RTL and testbench

//   Round-robin scheduler that shares one 4:1 mux output between four requesters.

---
 rtl/mux_rr_if.sv | 13 +
 rtl/mux_rr_scheduler.sv | 116 +++++++++++
 tb/tb_mux_rr_scheduler.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/mux_rr_if.sv
// Handshake bundle between the four requesters, the round-robin scheduler and the 4:1 mux.
// The scheduler takes the master view; producers and the mux take the slave view.
interface mux_rr_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       en;
  logic       busy;
  logic       switch;

  modport master (input req, output gnt, sel, en, busy, switch);
  modport slave  (output req, input gnt, sel, en, busy, switch);
endinterface

// File: rtl/mux_rr_scheduler.sv
// Round-robin owner scheduler for a shared 4:1 mux: time-sliced ownership with an
// optional break-before-make gap (en low) between owners.
module mux_rr_scheduler #(
  parameter int SLOT_CYCLES = 8,  // 1..255
  parameter int GAP_CYCLES  = 1   // 0..15, 0 = direct handover
) (
  input  logic      clk,
  input  logic      rst,
  mux_rr_if.master  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  localparam logic [7:0] SLOT_LAST = 8'(SLOT_CYCLES - 1);
  localparam logic [3:0] GAP_LAST  = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  logic [1:0] state;
  logic [7:0] slot_cnt;
  logic [3:0] gap_cnt;
  logic [1:0] last;
  logic [3:0] gnt_q;
  logic [1:0] sel_q;
  logic       en_q, busy_q, switch_q;

  // Returns {found, index}: first set request scanning from one past `from`, wrapping 3->0,
  // so `from` itself is the last candidate considered.
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] from);
    logic [1:0] idx;
    pick = 3'b000;
    for (int i = 4; i >= 1; i--) begin
      idx = from + 2'(i);
      if (r[idx]) pick = {1'b1, idx};
    end
  endfunction

  logic [2:0] win;
  logic       exit_now, slot_end, gap_done;
  logic       take_grant, to_gap, go_idle;

  assign win      = pick(bus.req, last);
  assign slot_end = (slot_cnt == SLOT_LAST);
  assign exit_now = (state == GRANT) &&
                    (!bus.req[sel_q] || (slot_end && |(bus.req & ~gnt_q)));
  assign gap_done = (state == GAP) && (gap_cnt == GAP_LAST);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    take_grant = 1'b0;
    to_gap     = 1'b0;
    go_idle    = 1'b0;
    case (state)
      IDLE:  take_grant = win[2];
      GRANT: if (exit_now) begin
               if (GAP_CYCLES > 0) to_gap = 1'b1;
               else if (win[2])    take_grant = 1'b1;
               else                go_idle = 1'b1;
             end
      GAP:   if (gap_done) begin
               take_grant = win[2];
               go_idle    = !win[2];
             end
      default: go_idle = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      slot_cnt <= 8'd0;
      gap_cnt  <= 4'd0;
      last     <= 2'd3;
      gnt_q    <= 4'b0000;
      sel_q    <= 2'b00;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      switch_q <= 1'b0;
    end else begin
      switch_q <= exit_now;

      if (take_grant) begin
        state    <= GRANT;
        gnt_q    <= 4'b0001 << win[1:0];
        sel_q    <= win[1:0];
        last     <= win[1:0];
        en_q     <= 1'b1;
        busy_q   <= 1'b1;
        slot_cnt <= 8'd0;
      end else if (to_gap) begin
        state   <= GAP;
        gnt_q   <= 4'b0000;
        en_q    <= 1'b0;
        gap_cnt <= 4'd0;
      end else if (go_idle) begin
        state  <= IDLE;
        gnt_q  <= 4'b0000;
        en_q   <= 1'b0;
        busy_q <= 1'b0;
      end else if (state == GRANT) begin
        // Slot expiry with nobody else waiting just starts a fresh slot for the same owner.
        slot_cnt <= slot_end ? 8'd0 : slot_cnt + 8'd1;
      end else if (state == GAP) begin
        gap_cnt <= gap_cnt + 4'd1;
      end
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.sel    = sel_q;
  assign bus.en     = en_q;
  assign bus.busy   = busy_q;
  assign bus.switch = switch_q;

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Scoreboard bench: three scheduler configurations share one req stream; a behavioural
// ownership model predicts every cycle's outputs, and a 4:1 mux is driven from DUT A.
module tb_mux_rr_scheduler;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       en;
    logic       busy;
    logic       sw;
  } exp_t;

  typedef struct {
    int owner;     // -1 when nobody holds the mux
    int held;      // cycles already spent in the current slot
    int gap_left;  // gap cycles remaining, including the current one
    int last;
    int sel;
    bit sw;
  } mstate_t;

  localparam int SLOT[3] = '{8, 8, 3};
  localparam int GAP[3]  = '{1, 0, 2};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [7:0] d [4];
  logic [7:0] y_a;

  int tests  = 0;
  int failed = 0;

  mstate_t     m [3];
  exp_t [2:0]  sb_q [$];

  mux_rr_if ifa ();
  mux_rr_if ifb ();
  mux_rr_if ifc ();
  assign ifa.req = req;
  assign ifb.req = req;
  assign ifc.req = req;

  mux_rr_scheduler #(.SLOT_CYCLES(8), .GAP_CYCLES(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  mux_rr_scheduler #(.SLOT_CYCLES(8), .GAP_CYCLES(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  mux_rr_scheduler #(.SLOT_CYCLES(3), .GAP_CYCLES(2)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

  // The shared 4:1 mux: Y follows D[sel] while enabled, otherwise 0.
  assign y_a = ifa.en ? d[ifa.sel] : 8'h00;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic mstate_t model_reset();
    mstate_t s;
    s.owner = -1; s.held = 0; s.gap_left = 0; s.last = 3; s.sel = 0; s.sw = 1'b0;
    return s;
  endfunction

  // Hand the mux to the first requester after the previous owner, wrapping around.
  function automatic mstate_t arb(mstate_t s, logic [3:0] r);
    mstate_t n = s;
    for (int k = 1; k <= 4; k++) begin
      int c = (s.last + k) % 4;
      if (r[c] && n.owner < 0) begin
        n.owner = c; n.sel = c; n.last = c; n.held = 0;
      end
    end
    return n;
  endfunction

  function automatic mstate_t step(mstate_t s, logic [3:0] r, int slot, int gap);
    mstate_t n = s;
    bit others;
    bit expired;
    n.sw = 1'b0;
    if (s.owner >= 0) begin
      others  = (r & ~(4'b0001 << s.owner)) != 4'b0000;
      expired = (s.held + 1 >= slot);
      if (!r[s.owner] || (expired && others)) begin
        n.sw    = 1'b1;
        n.owner = -1;
        if (gap > 0) n.gap_left = gap;
        else         n = arb(n, r);
      end else begin
        n.held = expired ? 0 : s.held + 1;
      end
    end else if (s.gap_left > 0) begin
      n.gap_left = s.gap_left - 1;
      if (n.gap_left == 0) n = arb(n, r);
    end else begin
      n = arb(n, r);
    end
    return n;
  endfunction

  function automatic exp_t expect_of(mstate_t s);
    exp_t e;
    e.gnt  = (s.owner >= 0) ? 4'(4'b0001 << s.owner) : 4'b0000;
    e.sel  = 2'(s.sel);
    e.en   = (s.owner >= 0);
    e.busy = (s.owner >= 0) || (s.gap_left > 0);
    e.sw   = s.sw;
    return e;
  endfunction

  // One stimulus cycle: apply req and fresh mux data at the falling edge, predict the
  // outputs after the next rising edge and queue them for the monitor.
  task automatic drive(input logic [3:0] r);
    exp_t [2:0] e;
    @(negedge clk);
    rst = 1'b0;
    req = r;
    for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
    for (int k = 0; k < 3; k++) begin
      m[k] = step(m[k], r, SLOT[k], GAP[k]);
      e[k] = expect_of(m[k]);
    end
    sb_q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_a"}, {ifa.gnt, ifa.sel, ifa.en, ifa.busy, ifa.switch}, 32'd0);
    check({tag, "_b"}, {ifb.gnt, ifb.sel, ifb.en, ifb.busy, ifb.switch}, 32'd0);
    check({tag, "_c"}, {ifc.gnt, ifc.sel, ifc.en, ifc.busy, ifc.switch}, 32'd0);
  endtask

  // Assert reset between edges and check the outputs clear with no clock edge.
  task automatic reset_mid();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    req = 4'b0000;
    sb_q.delete();
    for (int k = 0; k < 3; k++) m[k] = model_reset();
  endtask

  // Monitor: compares each queued prediction just after the edge it belongs to.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst && sb_q.size() > 0) begin
        exp_t [2:0] e;
        e = sb_q.pop_front();
        check("dut_a", {ifa.gnt, ifa.sel, ifa.en, ifa.busy, ifa.switch}, 32'(e[0]));
        check("dut_b", {ifb.gnt, ifb.sel, ifb.en, ifb.busy, ifb.switch}, 32'(e[1]));
        check("dut_c", {ifc.gnt, ifc.sel, ifc.en, ifc.busy, ifc.switch}, 32'(e[2]));
        check("mux_y", 32'(y_a), 32'(e[0].en ? d[e[0].sel] : 8'h00));
      end
    end
  end

  initial begin
    logic [3:0] r;
    for (int i = 0; i < 4; i++) d[i] = 8'h00;
    for (int k = 0; k < 3; k++) m[k] = model_reset();

    #2 rst = 1'b1;
    #1;
    check_reset_outputs("power_on_reset");
    repeat (2) @(posedge clk);

    // Single requester holds the mux across slot expiries with no switch.
    repeat (20) drive(4'b0100);

    // All requesting: full rotation with slot limits and gaps.
    repeat (40) drive(4'b1111);

    // Reset in the middle of a grant, then req0 must win first.
    reset_mid();
    repeat (3) drive(4'b1111);

    // Early release by owner 1 while req3 waits.
    repeat (4) drive(4'b0000);
    repeat (3) drive(4'b1010);
    repeat (6) drive(4'b1000);

    // Two requesters: handover behaviour for each gap setting.
    repeat (3) drive(4'b0000);
    repeat (30) drive(4'b0011);

    // Owner drops and re-raises during the gap.
    repeat (10) drive(4'b0001);
    drive(4'b0010);
    repeat (12) drive(4'b0011);

    // Random levels with persistence so slots both expire and end early.
    r = 4'($urandom);
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 19) == 0) r = 4'($urandom);
      else
        for (int b = 0; b < 4; b++)
          if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
      drive(r);
      if (n == 700) begin
        reset_mid();
      end
    end

    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
